// File: rtl/video_pattern_gen_if.sv
// Control inputs and video outputs of the pattern generator, bundled for port use.
// The master side is the generator; the slave side is the video consumer.
interface video_pattern_gen_if #(
  parameter int LANES = 2
) ();
  logic                  video_gen_en_i;
  logic                  repeat_en_i;
  logic [1:0]            mode_i;
  logic                  vsync_o;
  logic                  hsync_o;
  logic                  data_valid_o;
  logic                  frame_start_o;
  logic [24*LANES-1:0]   data_o;
  logic [15:0]           frame_cnt_o;

  modport master (
    input  video_gen_en_i, repeat_en_i, mode_i,
    output vsync_o, hsync_o, data_valid_o, frame_start_o, data_o, frame_cnt_o
  );

  modport slave (
    output video_gen_en_i, repeat_en_i, mode_i,
    input  vsync_o, hsync_o, data_valid_o, frame_start_o, data_o, frame_cnt_o
  );
endinterface

// File: rtl/video_pattern_gen.sv
// Parametrised video timing plus test-pattern source (bars, ramp, checker, moving box)
// delivering 1, 2 or 4 pixels per clock, all outputs registered.
module video_pattern_gen #(
  parameter int H_ACTIVE   = 1366,
  parameter int H_FP       = 70,
  parameter int H_SYNC     = 143,
  parameter int H_BP       = 213,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 24,
  parameter int LANES      = 2,
  parameter     HSYNC_POL  = "NEGATIVE",
  parameter     VSYNC_POL  = "NEGATIVE",
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 64,
  parameter int STEP_X     = 4,
  parameter int STEP_Y     = 2
) (
  input  logic               pixel_clock_i,
  input  logic               rst_i,
  video_pattern_gen_if.master vid
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST   = 16'(HT / LANES - 1);
  localparam logic [15:0] V_LAST   = 16'(VT - 1);
  localparam logic [15:0] HA_G     = 16'(H_ACTIVE / LANES);
  localparam logic [15:0] HS_START = 16'((H_ACTIVE + H_FP) / LANES);
  localparam logic [15:0] HS_END   = 16'((H_ACTIVE + H_FP + H_SYNC) / LANES);
  localparam logic [15:0] VA       = 16'(V_ACTIVE);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] BAR_W    = 16'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);
  localparam logic [16:0] BOX_W    = 17'(BOX_SIZE);
  localparam logic [15:0] SX       = 16'(STEP_X);
  localparam logic [15:0] SY       = 16'(STEP_Y);
  localparam logic [16:0] X_LIMIT  = 17'(H_ACTIVE);
  localparam logic [16:0] Y_LIMIT  = 17'(V_ACTIVE);
  localparam logic [16:0] X_REACH  = 17'(BOX_SIZE + STEP_X);
  localparam logic [16:0] Y_REACH  = 17'(BOX_SIZE + STEP_Y);

  localparam logic HS_ON = (HSYNC_POL == "POSITIVE");
  localparam logic VS_ON = (VSYNC_POL == "POSITIVE");

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [15:0] h_cnt, v_cnt;
  logic [1:0]  mode_q;
  logic [15:0] box_x, box_y;       // position the next frame will show
  logic        dir_x, dir_y;       // 1 = moving towards larger coordinates
  logic [15:0] shown_x, shown_y;   // position latched for the current frame

  logic                frame_first, active, hs_act, vs_act;
  logic [1:0]          eff_mode;
  logic [15:0]         eff_x, eff_y;
  logic [24*LANES-1:0] pix;

  function automatic logic [23:0] pixel(input logic [15:0] x, input logic [15:0] y,
                                        input logic [1:0] mode,
                                        input logic [15:0] bx, input logic [15:0] by);
    logic [15:0] bar;
    logic [2:0]  idx;
    logic        in_box;
    bar    = x / BAR_W;
    idx    = (bar > 16'd7) ? 3'd7 : bar[2:0];
    in_box = (x >= bx) && ({1'b0, x} < {1'b0, bx} + BOX_W) &&
             (y >= by) && ({1'b0, y} < {1'b0, by} + BOX_W);
    case (mode)
      // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
      2'd0:    pixel = {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
      2'd1:    pixel = {3{x[7:0]}};
      2'd2:    pixel = {24{x[CHECK_LOG2] ^ y[CHECK_LOG2]}};
      default: pixel = {24{in_box}};
    endcase
  endfunction

  // The first group of a frame must already use the freshly sampled mode and box.
  assign frame_first = (h_cnt == 16'd0) && (v_cnt == 16'd0);
  assign eff_mode    = frame_first ? vid.mode_i : mode_q;
  assign eff_x       = frame_first ? box_x : shown_x;
  assign eff_y       = frame_first ? box_y : shown_y;
  assign active      = (h_cnt < HA_G) && (v_cnt < VA);
  assign hs_act      = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_act      = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pix = '0;
    for (int k = 0; k < LANES; k++) begin
      pix[24*k +: 24] = pixel(h_cnt * 16'(LANES) + 16'(k), v_cnt, eff_mode, eff_x, eff_y);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge pixel_clock_i) begin
    if (rst_i) begin
      state             <= IDLE;
      h_cnt             <= '0;
      v_cnt             <= '0;
      mode_q            <= '0;
      box_x             <= '0;
      box_y             <= '0;
      dir_x             <= 1'b1;
      dir_y             <= 1'b1;
      shown_x           <= '0;
      shown_y           <= '0;
      vid.hsync_o       <= ~HS_ON;
      vid.vsync_o       <= ~VS_ON;
      vid.data_valid_o  <= 1'b0;
      vid.frame_start_o <= 1'b0;
      vid.data_o        <= '0;
      vid.frame_cnt_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          h_cnt             <= '0;
          v_cnt             <= '0;
          vid.hsync_o       <= ~HS_ON;
          vid.vsync_o       <= ~VS_ON;
          vid.data_valid_o  <= 1'b0;
          vid.frame_start_o <= 1'b0;
          vid.data_o        <= '0;
          if (vid.video_gen_en_i) state <= RUN;
        end

        RUN: begin
          vid.hsync_o       <= hs_act ? HS_ON : ~HS_ON;
          vid.vsync_o       <= vs_act ? VS_ON : ~VS_ON;
          vid.data_valid_o  <= active;
          vid.data_o        <= active ? pix : '0;
          vid.frame_start_o <= frame_first;

          if (frame_first) begin
            vid.frame_cnt_o <= vid.frame_cnt_o + 16'd1;
            mode_q          <= vid.mode_i;
            shown_x         <= box_x;
            shown_y         <= box_y;
            if (!vid.repeat_en_i) begin
              if (dir_x) begin
                if ({1'b0, box_x} + X_REACH > X_LIMIT) begin
                  dir_x <= 1'b0;
                  box_x <= box_x - SX;
                end else begin
                  box_x <= box_x + SX;
                end
              end else if (box_x < SX) begin
                dir_x <= 1'b1;
                box_x <= box_x + SX;
              end else begin
                box_x <= box_x - SX;
              end

              if (dir_y) begin
                if ({1'b0, box_y} + Y_REACH > Y_LIMIT) begin
                  dir_y <= 1'b0;
                  box_y <= box_y - SY;
                end else begin
                  box_y <= box_y + SY;
                end
              end else if (box_y < SY) begin
                dir_y <= 1'b1;
                box_y <= box_y + SY;
              end else begin
                box_y <= box_y - SY;
              end
            end
          end

          // Enable is only honoured at the last group of the frame.
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
              v_cnt <= '0;
              if (!vid.video_gen_en_i) state <= IDLE;
            end else begin
              v_cnt <= v_cnt + 16'd1;
            end
          end else begin
            h_cnt <= h_cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Two generator instances (2 lanes negative syncs, 4 lanes positive syncs) checked every
// cycle against a position-based reference model, plus directed pattern spot checks.
module tb_video_pattern_gen;

  typedef struct {
    int lanes, ha, hfp, hs, hbp, va, vfp, vs, vbp, cl, bs, sx, sy;
    bit hpos, vpos;
  } cfg_t;

  typedef struct {
    bit run;
    int pos, mode, bx, by, dbx, dby;
    bit dxp, dyp;
  } mdl_t;

  typedef struct {
    logic        hs, vs, dv, fs;
    logic [95:0] data;
    logic [15:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic       en  [2];
  logic       rep [2];
  logic [1:0] md  [2];

  cfg_t cfg [2];
  mdl_t m   [2];
  exp_t e   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  video_pattern_gen_if #(.LANES(2)) ifa ();
  video_pattern_gen_if #(.LANES(4)) ifb ();

  assign ifa.video_gen_en_i = en[0];
  assign ifa.repeat_en_i    = rep[0];
  assign ifa.mode_i         = md[0];
  assign ifb.video_gen_en_i = en[1];
  assign ifb.repeat_en_i    = rep[1];
  assign ifb.mode_i         = md[1];

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .LANES(2), .HSYNC_POL("NEGATIVE"), .VSYNC_POL("NEGATIVE"),
    .CHECK_LOG2(2), .BOX_SIZE(8), .STEP_X(4), .STEP_Y(0)
  ) u_a (
    .pixel_clock_i(clk),
    .rst_i        (rst),
    .vid          (ifa)
  );

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(4), .H_BP(8),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .LANES(4), .HSYNC_POL("POSITIVE"), .VSYNC_POL("POSITIVE"),
    .CHECK_LOG2(2), .BOX_SIZE(4), .STEP_X(4), .STEP_Y(2)
  ) u_b (
    .pixel_clock_i(clk),
    .rst_i        (rst),
    .vid          (ifb)
  );

  logic        obs_hs [2], obs_vs [2], obs_dv [2], obs_fs [2];
  logic [95:0] obs_data [2];
  logic [15:0] obs_fcnt [2];

  assign obs_hs[0]   = ifa.hsync_o;
  assign obs_vs[0]   = ifa.vsync_o;
  assign obs_dv[0]   = ifa.data_valid_o;
  assign obs_fs[0]   = ifa.frame_start_o;
  assign obs_data[0] = 96'(ifa.data_o);
  assign obs_fcnt[0] = ifa.frame_cnt_o;
  assign obs_hs[1]   = ifb.hsync_o;
  assign obs_vs[1]   = ifb.vsync_o;
  assign obs_dv[1]   = ifb.data_valid_o;
  assign obs_fs[1]   = ifb.frame_start_o;
  assign obs_data[1] = 96'(ifb.data_o);
  assign obs_fcnt[1] = ifb.frame_cnt_o;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference pixel colour straight from the pattern definitions.
  function automatic logic [23:0] ref_pixel(input cfg_t c, input int x, input int y,
                                            input int mode, input int bx, input int by);
    int idx;
    case (mode)
      0: begin
        idx = x / (c.ha / 8);
        if (idx > 7) idx = 7;
        case (idx)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return 24'(((x % 256) * 32'h010101));
      2: return ((((x >> c.cl) ^ (y >> c.cl)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default:
        return (x >= bx && x < bx + c.bs && y >= by && y < by + c.bs) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic bounce(input int p_in, input bit d_in, input int lim, input int sz, input int st,
                        output int p, output bit d);
    p = p_in;
    d = d_in;
    if (d_in) begin
      if (p_in + sz + st > lim) begin d = 1'b0; p = p_in - st; end
      else p = p_in + st;
    end else begin
      if (p_in < st) begin d = 1'b1; p = p_in + st; end
      else p = p_in - st;
    end
  endtask

  // Advance model i by one clock edge using the inputs present at that edge.
  task automatic model_edge(input int i);
    cfg_t c;
    int   hg, vt, line, grp, px, nx, ny;
    bit   ndx, ndy;
    c  = cfg[i];
    hg = (c.ha + c.hfp + c.hs + c.hbp) / c.lanes;
    vt = c.va + c.vfp + c.vs + c.vbp;
    if (rst) begin
      m[i].run = 1'b0; m[i].pos = 0;
      m[i].bx = 0; m[i].by = 0; m[i].dxp = 1'b1; m[i].dyp = 1'b1;
      e[i].hs = !c.hpos; e[i].vs = !c.vpos; e[i].dv = 1'b0; e[i].fs = 1'b0;
      e[i].data = '0; e[i].fcnt = '0;
    end else if (!m[i].run) begin
      e[i].hs = !c.hpos; e[i].vs = !c.vpos; e[i].dv = 1'b0; e[i].fs = 1'b0;
      e[i].data = '0;
      if (en[i]) m[i].run = 1'b1;
    end else begin
      line = m[i].pos / hg;
      grp  = m[i].pos % hg;
      px   = grp * c.lanes;
      e[i].fs = 1'b0;
      if (m[i].pos == 0) begin
        e[i].fs   = 1'b1;
        e[i].fcnt = e[i].fcnt + 16'd1;
        m[i].mode = int'(md[i]);
        m[i].dbx  = m[i].bx;
        m[i].dby  = m[i].by;
        if (!rep[i]) begin
          bounce(m[i].bx, m[i].dxp, c.ha, c.bs, c.sx, nx, ndx);
          bounce(m[i].by, m[i].dyp, c.va, c.bs, c.sy, ny, ndy);
          m[i].bx = nx; m[i].dxp = ndx; m[i].by = ny; m[i].dyp = ndy;
        end
      end
      e[i].hs = (px >= c.ha + c.hfp && px < c.ha + c.hfp + c.hs) ? c.hpos : !c.hpos;
      e[i].vs = (line >= c.va + c.vfp && line < c.va + c.vfp + c.vs) ? c.vpos : !c.vpos;
      e[i].dv = (px < c.ha) && (line < c.va);
      e[i].data = '0;
      if (e[i].dv) begin
        for (int k = 0; k < c.lanes; k++)
          e[i].data[24*k +: 24] = ref_pixel(c, px + k, line, m[i].mode, m[i].dbx, m[i].dby);
      end
      m[i].pos++;
      if (m[i].pos == hg * vt) begin
        m[i].pos = 0;
        if (!en[i]) m[i].run = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input int i);
    string n;
    n = (i == 0) ? "a" : "b";
    check({n, ".hsync"},       96'(obs_hs[i]),   96'(e[i].hs));
    check({n, ".vsync"},       96'(obs_vs[i]),   96'(e[i].vs));
    check({n, ".data_valid"},  96'(obs_dv[i]),   96'(e[i].dv));
    check({n, ".frame_start"}, 96'(obs_fs[i]),   96'(e[i].fs));
    check({n, ".data"},        obs_data[i],      e[i].data);
    check({n, ".frame_cnt"},   96'(obs_fcnt[i]), 96'(e[i].fcnt));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all(0);
    compare_all(1);
  endtask

  initial begin
    cfg[0] = '{lanes:2, ha:16, hfp:2, hs:2, hbp:4, va:8, vfp:1, vs:1, vbp:2,
               cl:2, bs:8, sx:4, sy:0, hpos:1'b0, vpos:1'b0};
    cfg[1] = '{lanes:4, ha:16, hfp:4, hs:4, hbp:8, va:8, vfp:1, vs:1, vbp:2,
               cl:2, bs:4, sx:4, sy:2, hpos:1'b1, vpos:1'b1};
    rst = 1'b1;
    en  = '{1'b0, 1'b0};
    rep = '{1'b0, 1'b0};
    md  = '{2'd0, 2'd1};
    #2;

    repeat (3) cyc();
    rst = 1'b0;
    repeat (3) cyc();

    // Start both generators: A shows bars, B shows the grey ramp.
    en = '{1'b1, 1'b1};
    cyc();
    cyc();
    check("a.first_valid", 96'(ifa.data_valid_o), 96'(1));
    check("a.first_start", 96'(ifa.frame_start_o), 96'(1));
    check("a.first_cnt",   96'(ifa.frame_cnt_o), 96'(1));
    check("a.bar_g0",      96'(ifa.data_o), 96'h000000000000_FFFFFF_FFFFFF);
    cyc();
    check("a.bar_g1",      96'(ifa.data_o), 96'h000000000000_FFFF00_FFFF00);
    cyc();
    check("b.ramp_g2",     96'(ifb.data_o), 96'h0B0B0B_0A0A0A_090909_080808);
    repeat (5) cyc();
    check("a.bar_g7_dv",   96'(ifa.data_valid_o), 96'(1));
    check("a.bar_g7",      96'(ifa.data_o), 96'(0));

    // Random mode switches (often mid-frame) and repeat toggles.
    for (int n = 0; n < 2400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 199) == 0) md[i] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 499) == 0) rep[i] = ~rep[i];
      end
      cyc();
    end

    // Moving box bouncing, then frozen.
    md  = '{2'd3, 2'd3};
    rep = '{1'b0, 1'b0};
    repeat (144 * 7) cyc();
    rep = '{1'b1, 1'b1};
    repeat (300) cyc();
    rep = '{1'b0, 1'b0};

    // Drop A's enable at line 3: the frame must still complete before idling.
    for (int n = 0; n < 200 && m[0].pos != 36; n++) cyc();
    en[0] = 1'b0;
    repeat (144 + 20) cyc();
    check("a.idle_valid", 96'(ifa.data_valid_o), 96'(0));
    check("a.idle_hsync", 96'(ifa.hsync_o), 96'(1));

    // Re-enable, then reset in the middle of a line.
    en[0] = 1'b1;
    md = '{2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
    repeat (40 + $urandom_range(0, 5)) cyc();
    rst = 1'b1;
    cyc();
    check("a.rst_valid", 96'(ifa.data_valid_o), 96'(0));
    check("a.rst_hsync", 96'(ifa.hsync_o), 96'(1));
    check("a.rst_vsync", 96'(ifa.vsync_o), 96'(1));
    check("a.rst_cnt",   96'(ifa.frame_cnt_o), 96'(0));
    check("b.rst_hsync", 96'(ifb.hsync_o), 96'(0));
    rst = 1'b0;
    cyc();
    check("a.restart_e0", 96'(ifa.data_valid_o), 96'(0));
    cyc();
    check("a.restart_e1", 96'(ifa.data_valid_o), 96'(1));
    check("a.restart_fs", 96'(ifa.frame_start_o), 96'(1));
    repeat (300) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
